// File: rtl/lenet_top.sv
// lenet_top: streaming 5x5 convolution, requantization, activation and 2x2 max pool over a 32x32 frame.
// Defining LENET_RELU_EN applies ReLU after requantization; otherwise the saturated value passes through.
module lenet_top #(
    parameter int MAPSIZE = 32,
    parameter int K       = 5,
    parameter int SHIFT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              data_valid_in,
    input  logic signed [7:0] pixel_in,
    output logic              data_valid_out,
    output logic signed [7:0] pixel_out,
    output logic              layer_done
);
    localparam int CW   = $clog2(MAPSIZE);
    localparam int CONV = MAPSIZE - K + 1;
    localparam int POOL = CONV / 2;
    localparam int NOUT = POOL * POOL;
    localparam int OW   = $clog2(NOUT + 1);
    localparam int PW   = $clog2(POOL);

    localparam logic signed [5:0] KERNEL [5][5] = '{
        '{ 6'sd0,  6'sd0, -6'sd1,  6'sd0,  6'sd0},
        '{ 6'sd0, -6'sd1, -6'sd2, -6'sd1,  6'sd0},
        '{-6'sd1, -6'sd2, 6'sd16, -6'sd2, -6'sd1},
        '{ 6'sd0, -6'sd1, -6'sd2, -6'sd1,  6'sd0},
        '{ 6'sd0,  6'sd0, -6'sd1,  6'sd0,  6'sd0}
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_row, r_col;
    logic              r_in_full;
    logic              r_win_vld;
    logic              r_cr_odd;
    logic [CW-1:0]     r_cc;
    logic signed [7:0] r_hmax;
    logic [OW-1:0]     r_out_cnt;
    logic              r_data_valid_out;
    logic signed [7:0] r_pixel_out;
    logic              r_layer_done;

    logic signed [7:0] r_lb       [K-1][MAPSIZE];
    logic signed [7:0] r_win      [K][K];
    logic signed [7:0] r_pool_buf [POOL];

    logic              w_accept;
    logic signed [19:0] w_acc, w_shr;
    logic signed [7:0] w_q8, w_act, w_pair, w_pool;
    logic [PW-1:0]     w_q;

    assign w_accept = (r_state == RUN) && data_valid_in && !r_in_full;

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w_acc = w_acc + 20'(r_win[i][j]) * 20'(KERNEL[i][j]);
    end

    assign w_shr = w_acc >>> SHIFT;

    // NOTE: every branch assigns w_q8, so no latch is inferred.
    always_comb begin
        if (w_shr > 20'sd127)
            w_q8 = 8'sd127;
        else if (w_shr < -20'sd128)
            w_q8 = 8'h80;
        else
            w_q8 = w_shr[7:0];
    end

`ifdef LENET_RELU_EN
    assign w_act = w_q8[7] ? 8'sd0 : w_q8;
`else
    assign w_act = w_q8;
`endif

    assign w_q    = PW'(r_cc >> 1);
    assign w_pair = (w_act > r_hmax) ? w_act : r_hmax;
    assign w_pool = (w_pair > r_pool_buf[w_q]) ? w_pair : r_pool_buf[w_q];

    // NOTE: storage arrays carry no reset; each entry is written before it is read within a frame.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K - 1; j++)
                    r_win[i][j] <= r_win[i][j+1];
            for (int i = 0; i < K - 1; i++)
                r_win[i][K-1] <= r_lb[i][r_col];
            r_win[K-1][K-1] <= pixel_in;
            for (int i = 0; i < K - 2; i++)
                r_lb[i][r_col] <= r_lb[i+1][r_col];
            r_lb[K-2][r_col] <= pixel_in;
        end
        if (r_state == RUN && r_win_vld && r_cc[0] && !r_cr_odd)
            r_pool_buf[w_q] <= w_pair;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_row            <= '0;
            r_col            <= '0;
            r_in_full        <= 1'b0;
            r_win_vld        <= 1'b0;
            r_cr_odd         <= 1'b0;
            r_cc             <= '0;
            r_hmax           <= '0;
            r_out_cnt        <= '0;
            r_data_valid_out <= 1'b0;
            r_pixel_out      <= '0;
            r_layer_done     <= 1'b0;
        end else begin
            r_data_valid_out <= 1'b0;
            r_layer_done     <= 1'b0;
            case (r_state)
                IDLE: if (start) r_state <= RUN;
                RUN: begin
                    if (w_accept) begin
                        r_win_vld <= (r_row >= CW'(K - 1)) && (r_col >= CW'(K - 1));
                        r_cr_odd  <= r_row[0];  // K-1 is even, so conv-row parity equals input-row parity
                        r_cc      <= r_col - CW'(K - 1);
                        if (r_col == CW'(MAPSIZE - 1)) begin
                            r_col <= '0;
                            if (r_row == CW'(MAPSIZE - 1))
                                r_in_full <= 1'b1;
                            else
                                r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end else begin
                        r_win_vld <= 1'b0;
                    end
                    if (r_win_vld) begin
                        if (!r_cc[0]) begin
                            r_hmax <= w_act;
                        end else if (r_cr_odd) begin
                            r_data_valid_out <= 1'b1;
                            r_pixel_out      <= w_pool;
                            r_out_cnt        <= r_out_cnt + 1'b1;
                        end
                    end
                    if (r_data_valid_out && r_out_cnt == OW'(NOUT)) begin
                        r_state      <= DONE;
                        r_layer_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_row     <= '0;
                    r_col     <= '0;
                    r_in_full <= 1'b0;
                    r_win_vld <= 1'b0;
                    r_cr_odd  <= 1'b0;
                    r_cc      <= '0;
                    r_hmax    <= '0;
                    r_out_cnt <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_valid_out = r_data_valid_out;
    assign pixel_out      = r_pixel_out;
    assign layer_done     = r_layer_done;

endmodule

// File: tb/tb_lenet_top.sv
// tb_lenet_top: frame-level vector table for lenet_top plus reset-abort and reset-state sequences.
module tb_lenet_top;
    logic              clk = 1'b0;
    logic              rst, start, data_valid_in;
    logic signed [7:0] pixel_in;
    logic              data_valid_out, layer_done;
    logic signed [7:0] pixel_out;

    always #5 clk = ~clk;

    lenet_top dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .data_valid_in (data_valid_in),
        .pixel_in      (pixel_in),
        .data_valid_out(data_valid_out),
        .pixel_out     (pixel_out),
        .layer_done    (layer_done)
    );

    typedef struct {
        string name;
        int    sel;
        bit    gap;
        int    exp0;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;
    int kw_tab [5][5] = '{'{0, 0, -1, 0, 0}, '{0, -1, -2, -1, 0}, '{-1, -2, 16, -2, -1},
                          '{0, -1, -2, -1, 0}, '{0, 0, -1, 0, 0}};

    int                cyc = 0;
    int                out_q[$];
    int                done_cnt, hold_err, last_out_cyc, done_cyc;
    logic signed [7:0] last_pix;
    logic              mon_rst = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_rst) begin
            out_q.delete();
            done_cnt     <= 0;
            hold_err     <= 0;
            last_out_cyc <= 0;
            done_cyc     <= 0;
            last_pix     <= pixel_out;
        end else begin
            if (data_valid_out) begin
                out_q.push_back(int'(pixel_out));
                last_out_cyc <= cyc;
                last_pix     <= pixel_out;
            end else if (pixel_out !== last_pix) begin
                hold_err <= hold_err + 1;
            end
            if (layer_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int img_px(input int sel, input int r, input int c);
        case (sel)
            0: return 0;
            1: return 50;
            2: return (r == 2 && c == 2) ? 8 : 0;
            3: begin
                if (r >= 5 || c >= 5) return 0;
                if (r == 2 && c == 2) return 127;
                return (kw_tab[r][c] != 0) ? -128 : 0;
            end
            default: return 0;
        endcase
    endfunction

    function automatic int model(input int sel, input int k);
        int p, q, best, s, r, c;
        p = k / 14;
        q = k % 14;
        best = -1000;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                r = 2 * p + dr;
                c = 2 * q + dc;
                s = 0;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        s += img_px(sel, r + i, c + j) * kw_tab[i][j];
                s = s >>> 4;
                if (s > 127) s = 127;
                if (s < -128) s = -128;
`ifdef LENET_RELU_EN
                if (s < 0) s = 0;
`endif
                if (s > best) best = s;
            end
        return best;
    endfunction

    task automatic drive(input logic v, input logic signed [7:0] p, input logic s);
        data_valid_in = v;
        pixel_in      = p;
        start         = s;
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        data_valid_in = 1'b0;
        start         = 1'b0;
        mon_rst       = 1'b1;
        @(posedge clk);
        #1;
        mon_rst = 1'b0;
    endtask

    // A start pulse mid-frame must be ignored; gapped mode idles every other cycle.
    task automatic feed_frame(input int sel, input bit gap, input int n_pix, output int end_cyc);
        int                idx;
        int                slot;
        logic signed [7:0] p8;
        idx  = 0;
        slot = 0;
        while (idx < n_pix) begin
            if (gap && (slot % 2 == 1)) begin
                drive(1'b0, 8'sd55, 1'b0);
            end else begin
                p8 = 8'(img_px(sel, idx / 32, idx % 32));
                drive(1'b1, p8, idx == 300);
                idx++;
            end
            slot++;
        end
        end_cyc = cyc;
    endtask

    task automatic run_frame(input vec_t v);
        int end_cyc;
        int waited;
        mon_clear();
        drive(1'b1, 8'sd77, 1'b0);
        drive(1'b1, -8'sd33, 1'b0);
        drive(1'b1, 8'sd99, 1'b1);
        feed_frame(v.sel, v.gap, 1024, end_cyc);
        repeat (3) drive(1'b1, 8'sd111, 1'b0);
        waited = 0;
        while (done_cnt == 0 && waited < 300) begin
            drive(1'b0, 8'sd0, 1'b0);
            waited++;
        end
        repeat (4) drive(1'b0, 8'sd0, 1'b0);
        check({v.name, " output count"}, out_q.size(), 196);
        check({v.name, " layer_done pulses"}, done_cnt, 1);
        check({v.name, " out[0] hand value"}, (out_q.size() > 0) ? out_q[0] : -999, v.exp0);
        for (int k = 0; k < 196; k++)
            check($sformatf("%s out[%0d]", v.name, k), (k < out_q.size()) ? out_q[k] : -999,
                  model(v.sel, k));
        check({v.name, " layer_done one cycle after last output"}, done_cyc - last_out_cyc, 1);
        check({v.name, " last output within 64 cycles"}, int'(last_out_cyc - end_cyc <= 64), 1);
        check({v.name, " pixel_out hold"}, hold_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int   ec;
        int   n_before;
        vec_t after_abort;

        vecs[0] = '{name: "zero image",       sel: 0, gap: 1'b0, exp0: 0};
        vecs[1] = '{name: "constant 50",      sel: 1, gap: 1'b0, exp0: 0};
        vecs[2] = '{name: "single 8",         sel: 2, gap: 1'b0, exp0: 8};
        vecs[3] = '{name: "saturate 127",     sel: 3, gap: 1'b0, exp0: 127};
        vecs[4] = '{name: "single 8 gapped",  sel: 2, gap: 1'b1, exp0: 8};
        after_abort = '{name: "single 8 after abort", sel: 2, gap: 1'b0, exp0: 8};

        rst = 1'b1;
        start = 1'b0;
        data_valid_in = 1'b0;
        pixel_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset data_valid_out", int'(data_valid_out), 0);
        check("reset pixel_out", int'(pixel_out), 0);
        check("reset layer_done", int'(layer_done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++)
            run_frame(vecs[i]);

        // Abandon a frame after 500 pixels; reset wins over start and valid in the same cycle.
        mon_clear();
        drive(1'b0, 8'sd0, 1'b1);
        feed_frame(3, 1'b0, 500, ec);
        rst = 1'b1;
        drive(1'b1, 8'sd5, 1'b1);
        rst = 1'b0;
        check("abort reset data_valid_out", int'(data_valid_out), 0);
        check("abort reset pixel_out", int'(pixel_out), 0);
        check("abort reset layer_done", int'(layer_done), 0);
        n_before = out_q.size();
        repeat (40) drive(1'b1, 8'sd9, 1'b0);
        check("no outputs after abort", out_q.size() - n_before, 0);
        check("no layer_done after abort", done_cnt, 0);
        run_frame(after_abort);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/lenet_top.md
LENET_TOP -- requirements
Module: lenet_top

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, the single clock; all logic on its rising edge.
REQ-002 SHALL have port `rst`: input, 1 bit, synchronous, active-high reset.
REQ-003 SHALL have port `start`: input, 1 bit, arms frame processing when sampled high in IDLE.
REQ-004 SHALL have port `data_valid_in`: input, 1 bit, qualifies `pixel_in` in the same cycle.
REQ-005 SHALL have port `pixel_in`: input, 8 bits, signed; raster-order pixel of a 32x32 image.
REQ-006 SHALL have port `data_valid_out`: output, 1 bit, one-cycle qualifier per pooled output.
REQ-007 SHALL have port `pixel_out`: output, 8 bits, signed; pooled feature value in raster order, 14x14 outputs.
REQ-008 SHALL have port `layer_done`: output, 1 bit, one-cycle end-of-frame pulse.
REQ-009 SHALL have parameters with these defaults: MAPSIZE=32 (input edge), K=5 (kernel edge), SHIFT=4 (requantization shift).

Function
REQ-010 SHALL implement an FSM with states IDLE, RUN and DONE; `start` in IDLE moves to RUN; `start` in RUN or DONE is ignored.
REQ-011 SHALL accept a pixel only in RUN with `data_valid_in`=1; pixels in IDLE, in the `start` cycle, or beyond pixel 1024 are discarded.
REQ-012 SHALL tolerate arbitrary gaps in `data_valid_in`; output values and order are independent of input timing.
REQ-013 SHALL hold a fixed internal 5x5 signed kernel, rows top to bottom: [0 0 -1 0 0], [0 -1 -2 -1 0], [-1 -2 16 -2 -1], [0 -1 -2 -1 0], [0 0 -1 0 0].
REQ-014 SHALL compute a valid convolution, conv(r,c) = sum over i,j 0..4 of px(r+i,c+j)*w(i,j), for r,c 0..27, with no padding.
REQ-015 SHALL use line buffers for 4 rows of 32 pixels plus a 5x5 window.
REQ-016 SHALL accumulate in at least 20-bit signed arithmetic with no overflow.
REQ-017 SHALL requantize as follows: arithmetic right shift by SHIFT (floor), then saturate to [-128,127].
REQ-018 SHALL apply the activation of REQ-028/REQ-029 after requantization.
REQ-019 SHALL compute the 2x2 stride-2 max pool as out(p,q) = max of act(2p..2p+1, 2q..2q+1), for p,q 0..13, compared signed.
REQ-020 SHALL emit exactly 196 outputs per frame in raster order (p major), each with a single-cycle `data_valid_out`.
REQ-021 SHALL hold `pixel_out` at its last value when `data_valid_out`=0.
REQ-022 SHALL keep latency such that the last output occurs no later than 64 cycles after the 1024th accepted pixel.
REQ-023 SHALL enter DONE in the cycle after the 196th output; `layer_done` is high for exactly that one cycle, then the FSM returns to IDLE.
REQ-024 SHALL make the next frame require a new `start`; all counters and the pool state clear on leaving DONE.

Reset
REQ-025 SHALL, with `rst`=1 at a clock edge, force IDLE and set `data_valid_out`=0, `pixel_out`=0, `layer_done`=0, and clear all counters.
REQ-026 SHALL treat reset mid-frame as abandoning the frame: no further outputs until a new `start`; line buffer contents need not be cleared.
REQ-027 SHALL give reset priority over `start` and `data_valid_in` in the same cycle.

Configuration
REQ-028 SHALL, with macro LENET_RELU_EN defined, apply ReLU: act = max(q,0), so `pixel_out` is in 0..127.
REQ-029 SHALL, with LENET_RELU_EN undefined, pass the saturated value unchanged (act = q), so `pixel_out` is in -128..127; all other behaviour is identical.

Verification
REQ-030 SHALL pass this scenario: all-zero image, continuous valid -> 196 outputs all 0, one `layer_done` pulse, none missing or extra.
REQ-031 SHALL pass this scenario: constant image of 50 -> every conv sum is 0 (kernel sums to 0) -> 196 zeros.
REQ-032 SHALL pass this scenario: a single pixel of 8 at (row 2, col 2), all others 0, ReLU on -> output index 0 = 8 and the remaining 195 outputs = 0.
REQ-033 SHALL pass this scenario: pixel 127 at (2,2) with its 12 nonzero-weight neighbours = -128 -> conv 4080 >>4 = 255, saturated -> output index 0 = 127.
REQ-034 SHALL pass this scenario: REQ-032 image fed with `data_valid_in` toggling every other cycle -> an identical 196-value sequence.
REQ-035 SHALL pass this scenario: `rst` asserted after 500 pixels, then `start` and a full REQ-032 frame -> exactly 196 correct outputs and one `layer_done`.
